// File: rtl/param_register_file.sv
// Multi-ported register file with write-to-read forwarding and a pending-write
// scoreboard that tracks registers whose producer has issued but not yet written.

module prf_rd_port #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] stored_i,
  input  logic              pend_i,
  input  logic              wr1_en_i,
  input  logic [ADDR_W-1:0] wr1_addr_i,
  input  logic [DATA_W-1:0] wr1_data_i,
  input  logic              wr2_en_i,
  input  logic [ADDR_W-1:0] wr2_addr_i,
  input  logic [DATA_W-1:0] wr2_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o
);
  logic hit1, hit2;

  // Write enables arrive already masked for the zero register, so address 0
  // never forwards and never reports busy when that register is hardwired.
  assign hit1 = (BYPASS != 0) && wr1_en_i && (wr1_addr_i == addr_i);
  assign hit2 = (BYPASS != 0) && wr2_en_i && (wr2_addr_i == addr_i);

  always_comb begin
    data_o = stored_i;
    if (hit1)      data_o = wr1_data_i;
    else if (hit2) data_o = wr2_data_i;
  end

  assign busy_o = pend_i && !(hit1 || hit2);
endmodule

module param_register_file #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 6,
  parameter int RD_PORTS = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                         clock_i,
  input  logic                         reset_ni,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr_i,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data_o,
  output logic [RD_PORTS-1:0]          rd_busy_o,
  input  logic [ADDR_W-1:0]            wr1_addr_i,
  input  logic [DATA_W-1:0]            wr1_data_i,
  input  logic                         wr1_enable_i,
  input  logic [ADDR_W-1:0]            wr2_addr_i,
  input  logic [DATA_W-1:0]            wr2_data_i,
  input  logic                         wr2_enable_i,
  input  logic                         reserve_enable_i,
  input  logic [ADDR_W-1:0]            reserve_addr_i,
  output logic                         reserve_reject_o,
  output logic                         conflict_o,
  output logic [ADDR_W:0]              pending_count_o
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              conflict_q, conflict_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic wr1_eff, wr2_eff, res_eff;
  logic wr1_z, wr2_z, res_z;

  assign wr1_z = (ZERO_REG != 0) && (wr1_addr_i == '0);
  assign wr2_z = (ZERO_REG != 0) && (wr2_addr_i == '0);
  assign res_z = (ZERO_REG != 0) && (reserve_addr_i == '0);

  assign wr1_eff = wr1_enable_i && !wr1_z;
  // wr2 loses to wr1 on an address collision
  assign wr2_eff = wr2_enable_i && !wr2_z && !(wr1_enable_i && (wr1_addr_i == wr2_addr_i));

  assign reserve_reject_o = reserve_enable_i && !res_z && pend_q[reserve_addr_i];
  assign res_eff          = reserve_enable_i && !res_z && !pend_q[reserve_addr_i];

  assign conflict_d = wr1_enable_i && wr2_enable_i && (wr1_addr_i == wr2_addr_i);

  // Clears first, then the set, so a same-cycle reservation outranks a write.
  always_comb begin
    pend_d = pend_q;
    if (wr1_eff) pend_d[wr1_addr_i] = 1'b0;
    if (wr2_eff) pend_d[wr2_addr_i] = 1'b0;
    if (res_eff) pend_d[reserve_addr_i] = 1'b1;
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + (ADDR_W+1)'(pend_d[i]);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pend_q     <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (wr2_eff) mem_q[wr2_addr_i] <= wr2_data_i;
      if (wr1_eff) mem_q[wr1_addr_i] <= wr1_data_i;
      pend_q     <= pend_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign conflict_o      = conflict_q;
  assign pending_count_o = cnt_q;

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr_i[k*ADDR_W +: ADDR_W];

    prf_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port (
      .addr_i     (addr),
      .stored_i   (mem_q[addr]),
      .pend_i     (pend_q[addr]),
      .wr1_en_i   (wr1_eff),
      .wr1_addr_i (wr1_addr_i),
      .wr1_data_i (wr1_data_i),
      .wr2_en_i   (wr2_eff),
      .wr2_addr_i (wr2_addr_i),
      .wr2_data_i (wr2_data_i),
      .data_o     (rd_data_o[k*DATA_W +: DATA_W]),
      .busy_o     (rd_busy_o[k])
    );
  end
endmodule
